// File: rtl/maxpool_seq_ctrl.sv
// Max-pool sequencer: windows a Qint8 stream and drives an external running-max comparator.
// Optional MAXPOOL_STALL_CNT_EN adds a saturating output-stall cycle counter.
module maxpool_seq_ctrl #(
  parameter int WIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [4:0]  cfg_win_len,
  input  logic [15:0] cfg_num_win,
  output logic        busy,
  output logic        done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        cmp_en,
  output logic        cmp_init,
  output logic [7:0]  cmp_data,
  input  logic [7:0]  cmp_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [31:0] stall_cnt
);

  localparam int CW = $clog2(WIN_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [CW-1:0] win_len;
  logic [CW-1:0] elem_cnt;
  logic [15:0]   num_win;
  logic [15:0]   win_cnt;
  logic [7:0]    last_data;
  logic          out_valid_q;
  logic [7:0]    out_data_q;

  logic [CW-1:0] win_len_clamp;
  logic          start_acc;
  logic          cfg_zero;
  logic          last_win;
  logic          acc;
  logic          last_elem;
  logic          out_hs;
  logic          final_hs;

  always_comb begin
    win_len_clamp = CW'(cfg_win_len);
    if (int'(cfg_win_len) > WIN_MAX) begin
      win_len_clamp = CW'(WIN_MAX);
    end
  end

  assign start_acc = (state == S_IDLE) && cfg_start;
  assign cfg_zero  = (cfg_win_len == 5'd0) || (cfg_num_win == 16'd0);
  assign last_win  = (win_cnt == num_win);

  assign in_ready = (state == S_RUN) && !last_win
                  && (!out_valid_q || out_ready);

  assign acc       = in_valid && in_ready;
  assign last_elem = acc && (elem_cnt == win_len - CW'(1));
  assign out_hs    = out_valid_q && out_ready;
  assign final_hs  = (state == S_RUN) && last_win && out_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_nxt = cfg_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (final_hs) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len  <= '0;
      num_win  <= '0;
      elem_cnt <= '0;
      win_cnt  <= '0;
    end else if (start_acc) begin
      win_len  <= win_len_clamp;
      num_win  <= cfg_num_win;
      elem_cnt <= '0;
      win_cnt  <= '0;
    end else if (acc) begin
      if (last_elem) begin
        elem_cnt <= '0;
        win_cnt  <= win_cnt + 16'd1;
      end else begin
        elem_cnt <= elem_cnt + CW'(1);
      end
    end
  end

  // Comparator sees the held byte when idle; re-comparing it is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data <= '0;
    end else if (acc) begin
      last_data <= in_data;
    end
  end

  // A one-element window bypasses the comparator: its stored max is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (last_elem) begin
      out_valid_q <= 1'b1;
      out_data_q  <= (win_len == CW'(1)) ? in_data : cmp_result;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign cmp_en    = acc;
  assign cmp_init  = acc && (elem_cnt == '0);
  assign cmp_data  = acc ? in_data : last_data;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

`ifdef MAXPOOL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
